uart_tx_arbiter: RTL

//   Shares one uartTx transmitter between N_REQ byte producers using round-robin arbitration.

---
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uartTx between N_REQ byte producers.
// uartTx has no busy flag, so frames are paced from a local counter of 7+STOP_BITS wait cycles.
module uart_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int STOP_BITS = 1,
    localparam int PTR_W    = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    output logic                 busy,
    output logic [PTR_W-1:0]     grant_id,
    output logic                 frame_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    localparam logic [4:0] CNT_LOAD = 5'(6 + STOP_BITS);

    state_t           state;
    state_t           state_next;
    logic [4:0]       cnt;
    logic [4:0]       cnt_next;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] pick;
    logic [PTR_W:0]   scan_idx;
    logic             found;
    logic             accept;

    // Scan ptr+1, ptr+2, ... modulo N_REQ; the first valid requester wins.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        found    = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            scan_idx = {1'b0, ptr} + (PTR_W+1)'(off);
            if (scan_idx >= (PTR_W+1)'(N_REQ)) begin
                scan_idx = scan_idx - (PTR_W+1)'(N_REQ);
            end
            if (!found && req_valid[scan_idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = scan_idx[PTR_W-1:0];
            end
        end
    end

    // req_ready is gated by rst so it drops the moment reset is asserted, even in IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = '0;
        tx_start   = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (found && rst) begin
                    accept          = 1'b1;
                    req_ready[pick] = 1'b1;
                    state_next      = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                tx_start   = 1'b1;
                busy       = 1'b1;
                cnt_next   = CNT_LOAD;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (cnt == 5'd0) begin
                    frame_done = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ptr      <= PTR_W'(N_REQ - 1);
            tx_data  <= '0;
            grant_id <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                tx_data  <= req_data[{pick, 3'b000} +: 8];
                grant_id <= pick;
                ptr      <= pick;
            end
        end
    end

endmodule
